// File: rtl/l1_cache_pkg.sv
// Shared types and constants for the L1 data cache sequencing controller.
package l1_cache_pkg;

    // Controller state encoding
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        TAG_CHECK = 2'd1,
        WRITEBACK = 2'd2,
        ALLOCATE  = 2'd3
    } state_t;

    // Write-data source select for the SRAM merge mux
    localparam logic SEL_CPU  = 1'b0;
    localparam logic SEL_DRAM = 1'b1;

    // DRAM address source select
    localparam logic ADDR_VICTIM = 1'b0;
    localparam logic ADDR_REQ    = 1'b1;

    localparam int unsigned CNT_WIDTH_DEFAULT = 16;

    // A missing line must be written back first only if it holds modified data
    function automatic logic needs_writeback(input logic valid, input logic dirty);
        return valid & dirty;
    endfunction

endpackage

// File: rtl/l1_cache_ctrl_sat_counter.sv
// Saturating up-counter used for the cache statistics.
module sat_counter #(
    parameter int unsigned width = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [width-1:0] count
);

    // Count increments, holding at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + width'(1);
        end
    end

endmodule

// File: rtl/l1_cache_ctrl.sv
// Sequencing controller for a direct-mapped, write-back, write-allocate L1 data cache.
module l1_cache_ctrl
    import l1_cache_pkg::*;
#(
    parameter int unsigned cnt_width = CNT_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cache_cs,
    input  logic                 cache_we,
    output logic                 cache_ack,
    input  logic                 cache_hit,
    input  logic                 cache_valid,
    input  logic                 cache_dirty_i,
    output logic                 cache_dirty_o,
    output logic                 sram_we,
    output logic                 sram_data_sel,
    output logic                 dram_addr_sel,
    output logic                 dram_cs,
    output logic                 dram_we,
    input  logic                 dram_ack,
    output logic                 busy,
    output logic [cnt_width-1:0] hit_count,
    output logic [cnt_width-1:0] miss_count,
    output logic [cnt_width-1:0] wb_count
);

    state_t state;
    state_t state_next;
    logic   refilled;
    logic   hit_inc;
    logic   miss_inc;
    logic   wb_inc;

    // Next-state decode
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (cache_cs) state_next = TAG_CHECK;
            end
            TAG_CHECK: begin
                if (!cache_cs || cache_hit) begin
                    state_next = IDLE;
                end else if (needs_writeback(cache_valid, cache_dirty_i)) begin
                    state_next = WRITEBACK;
                end else begin
                    state_next = ALLOCATE;
                end
            end
            WRITEBACK: begin
                if (dram_ack) state_next = ALLOCATE;
            end
            ALLOCATE: begin
                if (dram_ack) state_next = TAG_CHECK;
            end
            default: state_next = IDLE;
        endcase
    end

    // State, refill flag and state-decoded outputs, registered from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            refilled      <= 1'b0;
            busy          <= 1'b0;
            dram_cs       <= 1'b0;
            dram_we       <= 1'b0;
            dram_addr_sel <= ADDR_VICTIM;
        end else begin
            state         <= state_next;
            busy          <= (state_next != IDLE);
            dram_cs       <= (state_next == WRITEBACK) || (state_next == ALLOCATE);
            dram_we       <= (state_next == WRITEBACK);
            dram_addr_sel <= (state_next == ALLOCATE) ? ADDR_REQ : ADDR_VICTIM;
            if (state_next == IDLE) begin
                refilled <= 1'b0;
            end else if ((state == ALLOCATE) && dram_ack) begin
                refilled <= 1'b1;
            end
        end
    end

    // Request completion and SRAM write control, decoded from state and status
    always_comb begin
        cache_ack     = 1'b0;
        sram_we       = 1'b0;
        sram_data_sel = SEL_CPU;
        cache_dirty_o = 1'b0;
        case (state)
            TAG_CHECK: begin
                if (cache_cs && cache_hit) begin
                    cache_ack = 1'b1;
                    if (cache_we) begin
                        sram_we       = 1'b1;
                        sram_data_sel = SEL_CPU;
                        cache_dirty_o = 1'b1;
                    end
                end
            end
            ALLOCATE: begin
                if (dram_ack) begin
                    sram_we       = 1'b1;
                    sram_data_sel = SEL_DRAM;
                    cache_dirty_o = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Statistics events; a retry after refill is not counted as a hit
    always_comb begin
        hit_inc  = (state == TAG_CHECK) && cache_cs && cache_hit && !refilled;
        miss_inc = (state == TAG_CHECK) && cache_cs && !cache_hit;
        wb_inc   = (state == WRITEBACK) && dram_ack;
    end

    sat_counter #(.width(cnt_width)) u_hit_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (hit_inc),
        .count (hit_count)
    );

    sat_counter #(.width(cnt_width)) u_miss_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (miss_inc),
        .count (miss_count)
    );

    sat_counter #(.width(cnt_width)) u_wb_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (wb_inc),
        .count (wb_count)
    );

endmodule

// File: tb/tb_l1_cache_ctrl.sv
// Bench for l1_cache_ctrl: transaction timelines from the latency rules, counters as plain integers.
module tb_l1_cache_ctrl;

    logic clk;
    logic rst;
    logic cache_cs, cache_we, cache_hit, cache_valid, cache_dirty_i, dram_ack;

    logic        cache_ack, cache_dirty_o, sram_we, sram_data_sel;
    logic        dram_addr_sel, dram_cs, dram_we, busy;
    logic [15:0] hit_count, miss_count, wb_count;

    logic        cache_ack_s, cache_dirty_o_s, sram_we_s, sram_data_sel_s;
    logic        dram_addr_sel_s, dram_cs_s, dram_we_s, busy_s;
    logic [1:0]  hit_count_s, miss_count_s, wb_count_s;

    l1_cache_ctrl #(.cnt_width(16)) dut (
        .clk(clk), .rst(rst), .cache_cs(cache_cs), .cache_we(cache_we), .cache_ack(cache_ack),
        .cache_hit(cache_hit), .cache_valid(cache_valid), .cache_dirty_i(cache_dirty_i),
        .cache_dirty_o(cache_dirty_o), .sram_we(sram_we), .sram_data_sel(sram_data_sel),
        .dram_addr_sel(dram_addr_sel), .dram_cs(dram_cs), .dram_we(dram_we), .dram_ack(dram_ack),
        .busy(busy), .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
    );

    l1_cache_ctrl #(.cnt_width(2)) dut_s (
        .clk(clk), .rst(rst), .cache_cs(cache_cs), .cache_we(cache_we), .cache_ack(cache_ack_s),
        .cache_hit(cache_hit), .cache_valid(cache_valid), .cache_dirty_i(cache_dirty_i),
        .cache_dirty_o(cache_dirty_o_s), .sram_we(sram_we_s), .sram_data_sel(sram_data_sel_s),
        .dram_addr_sel(dram_addr_sel_s), .dram_cs(dram_cs_s), .dram_we(dram_we_s), .dram_ack(dram_ack),
        .busy(busy_s), .hit_count(hit_count_s), .miss_count(miss_count_s), .wb_count(wb_count_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output vector bits: ack, sram_we, data_sel, dirty_o, dram_cs, dram_we, addr_sel, busy
    localparam logic [7:0] E_IDLE  = 8'b0000_0000;
    localparam logic [7:0] E_TCBSY = 8'b0000_0001;
    localparam logic [7:0] E_WB    = 8'b0000_1101;
    localparam logic [7:0] E_FILL  = 8'b0000_1011;

    logic [7:0] exp_out;
    bit         chk_en;
    int         n_chk, n_fail;
    int         m_hit, m_miss, m_wb;
    int         cyc_cnt, req_start, lat, ack_cnt;

    function automatic void chk(input string name, input int act, input int expv);
        n_chk++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc_cnt);
        end
    endfunction

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // Compare both instances against the expected timeline and counter model every cycle
    always @(negedge clk) begin
        if (chk_en) begin
            chk("outputs", int'({cache_ack, sram_we, sram_data_sel, cache_dirty_o,
                                 dram_cs, dram_we, dram_addr_sel, busy}), int'(exp_out));
            chk("outputs_w2", int'({cache_ack_s, sram_we_s, sram_data_sel_s, cache_dirty_o_s,
                                    dram_cs_s, dram_we_s, dram_addr_sel_s, busy_s}), int'(exp_out));
            chk("hit_count", int'(hit_count), sat(m_hit, 16));
            chk("miss_count", int'(miss_count), sat(m_miss, 16));
            chk("wb_count", int'(wb_count), sat(m_wb, 16));
            chk("hit_count_w2", int'(hit_count_s), sat(m_hit, 2));
            chk("miss_count_w2", int'(miss_count_s), sat(m_miss, 2));
            chk("wb_count_w2", int'(wb_count_s), sat(m_wb, 2));
            if (cache_ack) begin
                lat = cyc_cnt - req_start + 1;
                ack_cnt++;
            end
        end
    end

    // One clock cycle: drive inputs, publish expectation, then account for counter events
    task automatic cyc(input logic r, cs, we, hit, valid, dirty, dack,
                       input logic [7:0] e, input bit ev_hit, ev_miss, ev_wb);
        cyc_cnt++;
        rst = r; cache_cs = cs; cache_we = we; cache_hit = hit;
        cache_valid = valid; cache_dirty_i = dirty; dram_ack = dack;
        exp_out = e;
        chk_en = 1'b1;
        @(posedge clk);
        #1;
        if (r) begin
            m_hit = 0; m_miss = 0; m_wb = 0;
        end else begin
            m_hit  += int'(ev_hit);
            m_miss += int'(ev_miss);
            m_wb   += int'(ev_wb);
        end
    endtask

    // One CPU request: IDLE, TAG_CHECK, optional write-back and refill, retry
    task automatic run_req(input logic we, hit, dirty, input int wb_lat, fill_lat, drop_at, rst_at);
        logic cs;
        logic last;
        cs = 1'b1;
        req_start = cyc_cnt + 1;
        cyc(0, 1, we, hit, 1, dirty, 0, E_IDLE, 0, 0, 0);
        if (hit) begin
            cyc(0, 1, we, 1, 1, dirty, 0, {1'b1, we, 1'b0, we, 4'b0001}, 1, 0, 0);
            return;
        end
        cyc(0, 1, we, 0, 1, dirty, 0, E_TCBSY, 0, 1, 0);
        if (dirty) begin
            for (int i = 0; i < wb_lat; i++) begin
                last = (i == wb_lat - 1);
                cyc(0, 1, we, 0, 1, dirty, last, E_WB, 0, 0, last);
            end
        end
        for (int i = 0; i < fill_lat; i++) begin
            if (i == drop_at) cs = 1'b0;
            if (i == rst_at) begin
                cyc(1, cs, we, 0, 1, dirty, 0, E_FILL, 0, 0, 0);
                return;
            end
            last = (i == fill_lat - 1);
            cyc(0, cs, we, 0, 1, dirty, last, {1'b0, last, last, 1'b0, 4'b1011}, 0, 0, 0);
        end
        if (cs) cyc(0, 1, we, 1, 1, 0, 0, {1'b1, we, 1'b0, we, 4'b0001}, 0, 0, 0);
        else    cyc(0, 0, we, 1, 1, 0, 0, E_TCBSY, 0, 0, 0);
    endtask

    task automatic idle_cycle(input logic dack);
        cyc(0, 0, 0, 0, 0, 0, dack, E_IDLE, 0, 0, 0);
    endtask

    initial begin
        int acks_before;
        n_chk = 0; n_fail = 0; m_hit = 0; m_miss = 0; m_wb = 0;
        cyc_cnt = 0; req_start = 0; lat = 0; ack_cnt = 0; chk_en = 1'b0;
        exp_out = E_IDLE;
        rst = 1'b1; cache_cs = 0; cache_we = 0; cache_hit = 0;
        cache_valid = 0; cache_dirty_i = 0; dram_ack = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state, with stray DRAM acks ignored in IDLE
        idle_cycle(0);
        idle_cycle(1);

        // Read hit
        run_req(0, 1, 0, 0, 0, -1, -1);
        chk("lat_read_hit", lat, 2);
        chk("hit_after_read", int'(hit_count), 1);
        idle_cycle(0);

        // Write hit
        run_req(1, 1, 0, 0, 0, -1, -1);
        chk("lat_write_hit", lat, 2);
        idle_cycle(0);

        // Clean miss, fill latency 3
        run_req(0, 0, 0, 0, 3, -1, -1);
        chk("lat_clean_miss", lat, 6);
        chk("miss_after_clean", int'(miss_count), 1);
        chk("hit_after_clean", int'(hit_count), 2);
        idle_cycle(1);

        // Dirty write miss, write-back latency 2, fill latency 2
        run_req(1, 0, 1, 2, 2, -1, -1);
        chk("lat_dirty_miss", lat, 7);
        chk("wb_after_dirty", int'(wb_count), 1);

        // Back-to-back hits with the request held, then a fifth hit
        run_req(0, 1, 0, 0, 0, -1, -1);
        run_req(1, 1, 0, 0, 0, -1, -1);
        run_req(0, 1, 0, 0, 0, -1, -1);
        chk("hit_count_5", int'(hit_count), 5);
        chk("hit_sat_w2", int'(hit_count_s), 3);
        idle_cycle(0);

        // Request withdrawn mid-refill: fill completes, no ack, back to IDLE
        acks_before = ack_cnt;
        run_req(0, 0, 0, 0, 3, 1, -1);
        chk("withdraw_no_ack", ack_cnt - acks_before, 0);
        idle_cycle(0);
        chk("miss_after_withdraw", int'(miss_count), 3);

        // Reset during refill abandons the DRAM request
        run_req(0, 0, 0, 0, 3, -1, 1);
        idle_cycle(0);
        chk("dram_cs_after_rst", int'(dram_cs), 0);
        chk("miss_after_rst", int'(miss_count), 0);
        idle_cycle(0);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
